// File: rtl/risac_bus_pkg.sv
// rtl/risac_bus_pkg.sv - shared encodings for the risac memory arbiter
//
// Purpose: state and owner encodings plus bus constants used by the
//          arbiter top and its priority sub-module.
// Ports:   none (package)
package risac_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Instruction fetches are always full-word.
  localparam logic [3:0] IBUS_BYTEEN = 4'b1111;

endpackage

// File: rtl/risac_arb_prio.sv
// rtl/risac_arb_prio.sv - dbus-priority grant with anti-starvation streak counter
//
// Purpose: combinational grant between ibus and dbus while the arbiter is
//          idle; dbus wins unless it has already won MAX_D_STREAK times in a
//          row against a waiting ibus.
// Ports:   clk, rst_n       clock, async active-low reset
//          arb_en           arbiter is idle and may grant
//          i_req, d_req     pending requests
//          grant_i, grant_d one-hot grant (both 0 when arb_en=0 or no request)
module risac_arb_prio #(
  parameter int MAX_D_STREAK = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output logic grant_i,
  output logic grant_d
);

  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

  logic [CNT_W-1:0] streak;
  logic             at_max;

  assign at_max  = (streak == STREAK_MAX);
  assign grant_d = arb_en & d_req & ~(i_req & at_max);
  assign grant_i = arb_en & i_req & (~d_req | at_max);

  // Only dbus wins taken while ibus was waiting count toward starvation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (grant_i) begin
      streak <= '0;
    end else if (grant_d && i_req && !at_max) begin
      streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/risac_mem_arbiter.sv
// rtl/risac_mem_arbiter.sv - shares one Avalon-MM slave between risac ibus and dbus
//
// Purpose: one-transaction-at-a-time arbiter in front of the single-port
//          program/data RAM. Command fields are captured at grant.
// Ports:   clk, rst_n                       clock, async active-low reset
//          i_addr/i_read                    ibus fetch request
//          i_data/i_iaddr/i_wait            fetch result, valid when i_wait=0
//          d_addr/d_read/d_we/d_wdata/d_byteen  dbus request
//          d_rdata/d_wait                   load data, stall to core
//          m_addr/m_read/m_write/m_wdata/m_byteen  slave command
//          m_rdata/m_waitrequest/m_readdatavalid   slave response
module risac_mem_arbiter
  import risac_bus_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  input  logic        i_read,
  output logic [31:0] i_data,
  output logic [31:0] i_iaddr,
  output logic        i_wait,
  input  logic [31:0] d_addr,
  input  logic        d_read,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic [31:0] d_rdata,
  output logic        d_wait,
  output logic [31:0] m_addr,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_byteen,
  input  logic [31:0] m_rdata,
  input  logic        m_waitrequest,
  input  logic        m_readdatavalid
);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  byteen_q;
  logic        write_q;
  logic        d_req;
  logic        grant_i, grant_d;
  logic        rsp_done;
  logic        i_match;

  assign d_req    = d_read | d_we;
  assign rsp_done = (state_q == ST_RESP) & m_readdatavalid;
  // Fetch result is only delivered if ibus still wants the same address.
  assign i_match  = i_read & (i_addr == addr_q);

  risac_arb_prio #(
    .MAX_D_STREAK (MAX_D_STREAK),
    .CNT_W        (CNT_W)
  ) u_prio (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_en  (state_q == ST_IDLE),
    .i_req   (i_read),
    .d_req   (d_req),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    m_read   = 1'b0;
    m_write  = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_byteen = '0;
    i_wait   = 1'b1;
    d_wait   = d_req;
    case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          state_d = ST_CMD;
          owner_d = OWN_D;
        end else if (grant_i) begin
          state_d = ST_CMD;
          owner_d = OWN_I;
        end
      end
      ST_CMD: begin
        m_read   = ~write_q;
        m_write  = write_q;
        m_addr   = addr_q;
        m_wdata  = wdata_q;
        m_byteen = byteen_q;
        if (!m_waitrequest) begin
          state_d = write_q ? ST_DONE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_readdatavalid) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // The owner's request is stale here, so return to IDLE without arbitrating.
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        if (owner_q == OWN_I) begin
          i_wait = ~i_match;
        end
        if (owner_q == OWN_D) begin
          d_wait = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Command capture at grant; a store wins over a load if both are raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      byteen_q <= '0;
      write_q  <= 1'b0;
    end else if (grant_d) begin
      addr_q   <= d_addr;
      wdata_q  <= d_wdata;
      byteen_q <= d_byteen;
      write_q  <= d_we;
    end else if (grant_i) begin
      addr_q   <= i_addr;
      wdata_q  <= '0;
      byteen_q <= IBUS_BYTEEN;
      write_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_data  <= '0;
      i_iaddr <= '0;
      d_rdata <= '0;
    end else if (rsp_done) begin
      if (owner_q == OWN_D) begin
        d_rdata <= m_rdata;
      end
      if (owner_q == OWN_I && i_match) begin
        i_data  <= m_rdata;
        i_iaddr <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_risac_mem_arbiter.sv
// tb/tb_risac_mem_arbiter.sv - scoreboard testbench for risac_mem_arbiter
module tb_risac_mem_arbiter;

  localparam int K_RD = 0;  // slave read command
  localparam int K_WR = 1;  // slave write command
  localparam int K_IR = 2;  // ibus fetch result
  localparam int K_DR = 3;  // dbus load result
  localparam int K_DW = 4;  // dbus store completion

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_addr, i_data, i_iaddr;
  logic        i_read, i_wait;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_read, d_we, d_wait;
  logic [3:0]  d_byteen;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_read, m_write;
  logic [3:0]  m_byteen;
  logic        m_waitrequest, m_readdatavalid;

  always #5 clk = ~clk;

  risac_mem_arbiter #(.MAX_D_STREAK(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_read(i_read), .i_data(i_data), .i_iaddr(i_iaddr), .i_wait(i_wait),
    .d_addr(d_addr), .d_read(d_read), .d_we(d_we), .d_wdata(d_wdata), .d_byteen(d_byteen),
    .d_rdata(d_rdata), .d_wait(d_wait),
    .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata), .m_byteen(m_byteen),
    .m_rdata(m_rdata), .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid)
  );

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ev_t;

  ev_t         sb[$];
  ev_t         mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          cmd_cycles = 0;
  int          rd_cycles = 0;
  int          ws_cfg = 0;
  int          rv_cfg = 1;
  logic [31:0] mem [logic [31:0]];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] val);
    n_checks++;
    n_fail++;
    $display("FAIL unexpected_%s: got event with value %0h expected no event", name, val);
  endtask

  function automatic void push(input int k, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.be = be;
    sb.push_back(e);
  endfunction

  // Monitor: compares every observed DUT output event against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_read || m_write) begin
        cmd_cycles++;
        if (m_read) rd_cycles++;
        if (sb.size() == 0) begin
          unexpected("cmd", m_addr);
        end else begin
          mon_e = sb[0];
          chk("cmd", {m_read, m_write, m_addr, (mon_e.kind == K_WR) ? m_wdata : 32'h0, m_byteen},
              {mon_e.kind == K_RD, mon_e.kind == K_WR, mon_e.addr,
               (mon_e.kind == K_WR) ? mon_e.data : 32'h0, mon_e.be});
          if (!m_waitrequest) void'(sb.pop_front());
        end
      end
      if (!i_wait) begin
        if (sb.size() == 0) begin
          unexpected("i_resp", i_iaddr);
        end else begin
          mon_e = sb.pop_front();
          chk("i_resp", {32'(K_IR), i_iaddr, i_data}, {32'(mon_e.kind), mon_e.addr, mon_e.data});
        end
      end
      if ((d_read || d_we) && !d_wait) begin
        if (sb.size() == 0) begin
          unexpected("d_resp", d_rdata);
        end else begin
          mon_e = sb.pop_front();
          chk("d_resp", {32'(d_we ? K_DW : K_DR), d_we ? 32'h0 : d_rdata},
              {32'(mon_e.kind), (mon_e.kind == K_DW) ? 32'h0 : mon_e.data});
        end
      end
    end
  end

  // Slave model: ws_cfg cycles of waitrequest, readdatavalid rv_cfg cycles after accept.
  initial begin
    int          ws_left;
    int          rv_left;
    logic        rv_pend;
    logic        in_cmd;
    logic [31:0] rv_data;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_rdata = '0;
    ws_left = 0; rv_left = 0; rv_pend = 1'b0; in_cmd = 1'b0; rv_data = '0;
    forever begin
      @(posedge clk);
      #2;
      m_readdatavalid = 1'b0;
      if (rv_pend) begin
        if (rv_left <= 1) begin
          m_readdatavalid = 1'b1;
          m_rdata = rv_data;
          rv_pend = 1'b0;
        end else begin
          rv_left--;
        end
      end
      if (m_read || m_write) begin
        if (!in_cmd) begin
          in_cmd = 1'b1;
          ws_left = ws_cfg;
        end
        if (ws_left > 0) begin
          m_waitrequest = 1'b1;
          ws_left--;
        end else begin
          m_waitrequest = 1'b0;
          in_cmd = 1'b0;
          if (m_read) begin
            rv_pend = 1'b1;
            rv_left = rv_cfg;
            rv_data = mem.exists(m_addr) ? mem[m_addr] : 32'hBAD0_0000;
          end else begin
            mem[m_addr] = m_wdata;
          end
        end
      end else begin
        m_waitrequest = 1'b0;
        in_cmd = 1'b0;
      end
    end
  end

  task automatic wait_empty(input string name, output int at_cyc);
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    at_cyc = cyc;
    chk({name, "_outstanding"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_accept(input string name, input logic [31:0] addr);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk); #1;
      seen = m_read && !m_waitrequest && (m_addr == addr);
      n++;
    end
    chk({name, "_accept_seen"}, seen, 1);
  endtask

  task automatic do_fetch(input logic [31:0] addr, input int ws, input int rv,
                          input logic [31:0] exp_data, input int exp_lat);
    int t0, t1;
    ws_cfg = ws; rv_cfg = rv; cmd_cycles = 0;
    @(posedge clk); #1;
    t0 = cyc;
    push(K_RD, addr, 32'h0, 4'hF);
    push(K_IR, addr, exp_data, 4'h0);
    i_addr = addr; i_read = 1'b1;
    wait_empty("fetch", t1);
    chk("fetch_latency", t1 - t0, exp_lat);
    chk("fetch_cmd_cycles", cmd_cycles, ws + 1);
    @(posedge clk); #1;
    i_read = 1'b0;
  endtask

  task automatic do_dbus(input logic we, input logic rd, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int ws,
                         input int rv, input logic [31:0] exp_data, input int exp_lat,
                         input logic scramble);
    int t0, t1;
    ws_cfg = ws; rv_cfg = rv; cmd_cycles = 0; rd_cycles = 0;
    @(posedge clk); #1;
    t0 = cyc;
    push(we ? K_WR : K_RD, addr, wdata, be);
    push(we ? K_DW : K_DR, addr, exp_data, 4'h0);
    d_addr = addr; d_wdata = wdata; d_byteen = be; d_we = we; d_read = rd;
    if (scramble) begin
      @(posedge clk); @(posedge clk); #1;
      d_addr = 32'hFFFF_FFFC; d_wdata = 32'h0; d_byteen = 4'h0;
    end
    wait_empty(we ? "store" : "load", t1);
    chk(we ? "store_latency" : "load_latency", t1 - t0, exp_lat);
    chk("dbus_cmd_cycles", cmd_cycles, ws + 1);
    if (we) chk("store_no_read", rd_cycles, 0);
    @(posedge clk); #1;
    d_we = 1'b0; d_read = 1'b0;
  endtask

  initial begin
    int   t_unused;
    logic rdv_seen;
    mem[32'h10]  = 32'h0050_0093;
    mem[32'h20]  = 32'h0000_0013;
    mem[32'h40]  = 32'h00A0_0113;
    mem[32'h300] = 32'h1234_5678;
    rst_n = 1'b0;
    i_addr = '0; i_read = 1'b0; d_addr = '0; d_read = 1'b0; d_we = 1'b0;
    d_wdata = '0; d_byteen = '0;

    // Reset with random ibus/dbus fields
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      i_addr = $urandom; i_read = 1'($urandom_range(0, 1));
      d_addr = $urandom; d_wdata = $urandom; d_byteen = 4'($urandom_range(0, 15));
      @(negedge clk);
      chk("reset_state", {m_read, m_write, m_addr, m_wdata, m_byteen, i_wait, d_wait,
                          i_data, i_iaddr, d_rdata}, {2'b00, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0,
                          32'h0, 32'h0, 32'h0});
    end
    @(posedge clk); #1;
    i_read = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_after_reset", {m_read, m_write, i_wait, d_wait}, 4'b0010);
    end

    // Ibus fetch, readdatavalid two cycles after accept
    do_fetch(32'h10, 0, 2, 32'h0050_0093, 4);
    // Dbus store with three waitrequest cycles and fields changed after grant
    do_dbus(1'b1, 1'b0, 32'h200, 32'hDEAD_BEEF, 4'h3, 3, 1, 32'h0, 5, 1'b1);
    // Zero-wait store with d_read also high (treated as write)
    do_dbus(1'b1, 1'b1, 32'h204, 32'hCAFE_F00D, 4'hC, 0, 1, 32'h0, 2, 1'b0);
    // Zero-wait load
    do_dbus(1'b0, 1'b1, 32'h300, 32'h0, 4'hF, 0, 1, 32'h1234_5678, 3, 1'b0);

    // Contention, MAX_D_STREAK=2: D,D,I,D,D,I
    ws_cfg = 0; rv_cfg = 1;
    @(posedge clk); #1;
    for (int g = 0; g < 6; g++) begin
      if (g == 2 || g == 5) begin
        push(K_RD, 32'h20, 32'h0, 4'hF);
        push(K_IR, 32'h20, 32'h0000_0013, 4'h0);
      end else begin
        push(K_RD, 32'h300, 32'h0, 4'hF);
        push(K_DR, 32'h300, 32'h1234_5678, 4'h0);
      end
    end
    i_addr = 32'h20; i_read = 1'b1;
    d_addr = 32'h300; d_byteen = 4'hF; d_read = 1'b1;
    wait_empty("contention", t_unused);
    @(posedge clk); #1;
    i_read = 1'b0; d_read = 1'b0;

    // Ibus redirect during RESP
    ws_cfg = 0; rv_cfg = 3;
    @(posedge clk); #1;
    push(K_RD, 32'h10, 32'h0, 4'hF);
    i_addr = 32'h10; i_read = 1'b1;
    wait_accept("redirect_first", 32'h10);
    @(posedge clk); #1;
    i_addr = 32'h40;
    push(K_RD, 32'h40, 32'h0, 4'hF);
    push(K_IR, 32'h40, 32'h00A0_0113, 4'h0);
    wait_accept("redirect_second", 32'h40);
    chk("redirect_discarded", {i_iaddr, i_data}, {32'h20, 32'h0000_0013});
    wait_empty("redirect", t_unused);
    @(posedge clk); #1;
    i_read = 1'b0;

    // Reset during RESP; late readdatavalid must be ignored
    ws_cfg = 0; rv_cfg = 4;
    @(posedge clk); #1;
    push(K_RD, 32'h80, 32'h0, 4'hF);
    i_addr = 32'h80; i_read = 1'b1;
    wait_accept("reset_resp", 32'h80);
    @(posedge clk); #1;
    rst_n = 1'b0; i_read = 1'b0;
    #1;
    chk("async_reset", {m_read, m_write, m_addr, m_byteen, i_wait, d_wait, i_data, i_iaddr},
        {2'b00, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 32'h0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdv_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (m_readdatavalid) rdv_seen = 1'b1;
    end
    chk("late_rdv_seen", rdv_seen, 1);
    chk("post_reset_held", {i_data, i_iaddr, d_rdata, i_wait}, {96'h0, 1'b1});
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1);
  end

endmodule

// File: doc/risac_mem_arbiter.md
Name: risac_mem_arbiter

Overview:
- Shares one Avalon-MM memory slave port (on-chip RAM) between the core instruction bus (read-only) and the core data bus (read/write).
- Sits between the risac core and the single-port program/data memory in the SoC.
- One transaction in flight at a time.
- Data bus has priority; a streak counter prevents instruction-fetch starvation.

Parameters:
MAX_D_STREAK, 4, max consecutive dbus grants while ibus is requesting before ibus is forced
CNT_W, 3, width of streak counter; must hold MAX_D_STREAK

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
i_addr  in  32  ibus byte address
i_read  in  1  ibus read request
i_data  out  32  fetched instruction
i_iaddr  out  32  address of i_data
i_wait  out  1  0 only in the cycle i_data/i_iaddr are valid
d_addr  in  32  dbus byte address
d_read  in  1  dbus load request
d_we  in  1  dbus store request
d_wdata  in  32  store data
d_byteen  in  4  byte enables
d_rdata  out  32  load data
d_wait  out  1  stall to core
m_addr  out  32  slave address
m_read  out  1  slave read
m_write  out  1  slave write
m_wdata  out  32  slave write data
m_byteen  out  4  slave byte enables (4'b1111 for ibus)
m_rdata  in  32  slave read data
m_waitrequest  in  1  slave not accepting command
m_readdatavalid  in  1  m_rdata valid

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, owner=NONE, streak=0. All m_* outputs 0. i_data, i_iaddr, d_rdata = 0. i_wait=1, d_wait=0.
- Masters hold requests stable until released. Command fields are captured into registers at grant, so later master changes do not reach the slave.
- States:
  - IDLE: arbitrate.
  - CMD: m_read or m_write asserted from the captured registers. Held until sampled with m_waitrequest=0. Then write -> DONE, read -> RESP.
  - RESP: wait for m_readdatavalid. Capture m_rdata, -> DONE. m_readdatavalid outside RESP is ignored.
  - DONE: one cycle, completion pulse to owner, -> IDLE. The owner's request is stale this cycle, so no arbitration happens in DONE.
- Arbitration in IDLE:
  - Only dbus requesting (d_read|d_we): grant dbus.
  - Only ibus requesting: grant ibus.
  - Both requesting: dbus wins unless streak==MAX_D_STREAK, then ibus wins.
  - streak increments (saturating) on a dbus grant made while i_read=1. It clears on any ibus grant.
  - d_read and d_we both high: treated as write.
- d_wait = (d_read|d_we) & ~(state==DONE & owner==D). It is 0 when dbus is idle.
- i_wait = ~(state==DONE & owner==I & i_read & i_addr==captured addr).
  - If ibus dropped i_read or changed i_addr mid-transaction, the result is discarded: i_wait stays 1 and i_data is not updated.
  - The memory read still completes and is never aborted.
- Data returns: i_data/i_iaddr and d_rdata are registers loaded at RESP->DONE. They hold their values otherwise.
- Latency with zero waitrequest and readdatavalid one cycle after accept: request at cycle t, CMD at t+1, RESP at t+2, DONE (wait low) at t+3. Write: DONE at t+2.
- Reset mid-transaction: immediate return to reset values. An in-flight slave response arriving after reset is ignored because state is IDLE.

Decomposition:
- Shared package risac_bus_pkg holds:
  - state encoding: IDLE, CMD, RESP, DONE (2-bit)
  - owner encoding: NONE, I, D
  - the ibus byte-enable constant 4'b1111
- One natural sub-module: risac_arb_prio, containing the combinational grant plus the streak counter register.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all m_* 0, i_wait=1, d_wait=0. Release, no requests -> stays IDLE.
- Ibus fetch: i_addr=0x10, i_read=1, slave returns 0x00500093 with readdatavalid 2 cycles after accept -> m_read/m_addr=0x10/m_byteen=4'hF for one cycle. Then one cycle of i_wait=0 with i_data=0x00500093 and i_iaddr=0x10.
- Dbus store with backpressure: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_byteen=4'h3, m_waitrequest=1 for 3 cycles -> m_write held 4 cycles with stable fields. d_wait=0 exactly one cycle after accept, no m_read.
- Contention: i_read and d_read high continuously with MAX_D_STREAK=2 -> grant order D,D,I,D,D,I. streak clears on each I grant.
- Ibus redirect: i_addr changes 0x10->0x40 during RESP -> DONE for 0x10 gives no i_wait=0 pulse. Next arbitration fetches 0x40 and returns i_iaddr=0x40.
- Reset mid-RESP: assert rst_n=0 during RESP, release, then slave pulses m_readdatavalid -> ignored. No wait-low pulse on either bus.
